// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with an optional second (skid) entry so that
// in_ready can be driven from a flop instead of from out_ready.
module pipe_skid_reg #(
  parameter int unsigned DATA_W   = 128,
  parameter bit          SKID     = 1'b1,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              main_valid_q, main_valid_d;
  logic [31:0]       main_pc_q,    main_pc_d;
  logic [31:0]       main_instr_q, main_instr_d;
  logic [DATA_W-1:0] main_data_q,  main_data_d;

  logic              skid_valid_q, skid_valid_d;
  logic [31:0]       skid_pc_q,    skid_pc_d;
  logic [31:0]       skid_instr_q, skid_instr_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;

  logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

  logic accept;
  logic consume;

  // With the skid entry present, a full skid is the only reason to refuse
  // input, so in_ready never looks at out_ready.
  assign in_ready = SKID ? ~skid_valid_q : (~main_valid_q | out_ready);
  assign accept   = in_valid & in_ready & ~flush;
  assign consume  = main_valid_q & out_ready;

  always_comb begin
    // NOTE: every variable gets a hold default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    main_valid_d = main_valid_q;
    main_pc_d    = main_pc_q;
    main_instr_d = main_instr_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    skid_data_d  = skid_data_q;
    stall_cnt_d  = stall_cnt_q;

    if (flush) begin
      main_valid_d = 1'b0;
      main_pc_d    = in_pc;
      main_instr_d = '0;
      main_data_d  = '0;
      skid_valid_d = 1'b0;
    end else if (consume && skid_valid_q) begin
      main_pc_d    = skid_pc_q;
      main_instr_d = skid_instr_q;
      main_data_d  = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (accept && (!main_valid_q || consume)) begin
      main_valid_d = 1'b1;
      main_pc_d    = in_pc;
      main_instr_d = in_instr;
      main_data_d  = in_data;
    end else if (accept) begin
      // Only reachable with SKID=1: main is busy and not draining.
      skid_valid_d = 1'b1;
      skid_pc_d    = in_pc;
      skid_instr_d = in_instr;
      skid_data_d  = in_data;
    end else if (consume) begin
      main_valid_d = 1'b0;
      main_instr_d = '0;
    end

    if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    if (reset) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= RESET_PC;
      main_instr_q <= '0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_instr_q <= main_instr_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // NOTE: the skid payload is never observed unless skid_valid_q is set, so
  // it is left without reset like any storage array.
  always_ff @(posedge clk) begin
    skid_pc_q    <= skid_pc_d;
    skid_instr_q <= skid_instr_d;
    skid_data_q  <= skid_data_d;
  end

  assign out_valid = main_valid_q;
  assign out_pc    = main_pc_q;
  assign out_instr = main_instr_q;
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule
